// File: rtl/rv32i_types.sv
// Purpose: shared RV32I front-end types (opcode enum, fetch packet) used by fetch, queue and decode.
// Latency: n/a (types, constants and a pure packing helper only).
// Backpressure: n/a.
package rv32i_types;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0060;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] instr;
        rv32i_opcode opcode;
    } pc_info_t;

    // Prediction fields are filled further down the pipe; fetch leaves them zero.
    typedef struct packed {
        pc_info_t    pc_info;
        logic        bp_taken;
        logic [31:0] bp_target;
    } pci_t;

    function automatic pci_t make_pci(input logic [31:0] pc,
                                      input logic [31:0] next_pc,
                                      input logic [31:0] rdata);
        pci_t p;
        p                = '0;
        p.pc_info.pc      = pc;
        p.pc_info.next_pc = next_pc;
        p.pc_info.instr   = rdata;
        p.pc_info.opcode  = rv32i_opcode'(rdata[6:0]);
        return p;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_register.sv
// Purpose: program counter with reset value, flush redirect and sequential +PC_STEP advance.
// Latency: 1 cycle from advance/flush to the new pc; pc_seq is combinational from pc.
// Backpressure: none; the caller only raises advance when a word is actually accepted.
// Ports: clk/rst; advance (step pc); flush + flush_pc (redirect, wins over advance);
//        pc (current fetch pc); pc_seq (pc + PC_STEP, wraps modulo 2^32).
module pc_register
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_seq
);

    assign pc_seq = pc + 32'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= flush_pc;
        end else if (advance) begin
            pc <= pc_seq;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Purpose: fetch stage; one outstanding I-cache read at a time, packs word+pc into the instruction queue.
// Latency: enq is combinational with icache_resp (0 cycles after the cache returns data).
// Backpressure: iq_full parks the returned word in a hold register and stops reading until space frees.
// Ports: clk/rst (sync, active-high); flush/flush_pc redirect; iq_full/iq_enq/iq_data queue push;
//        icache_read/icache_address request (held until icache_resp); icache_rdata/icache_resp return.
module instr_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        iq_full,
    output logic        iq_enq,
    output pci_t        iq_data,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DISCARD
    } fetch_state_t;

    fetch_state_t state, state_nxt;
    pci_t         hold_pkt;
    logic         hold_ld;
    logic [31:0]  disc_addr;
    logic         advance;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .flush    (flush),
        .flush_pc (flush_pc),
        .pc       (pc),
        .pc_seq   (pc_seq)
    );

    always_comb begin
        state_nxt      = state;
        iq_enq         = 1'b0;
        iq_data        = '0;
        icache_read    = 1'b0;
        icache_address = '0;
        advance        = 1'b0;
        hold_ld        = 1'b0;

        case (state)
            REQ: begin
                icache_read    = 1'b1;
                icache_address = pc;
                if (flush) begin
                    // A read still in flight must be drained before the redirect target is issued.
                    state_nxt = icache_resp ? REQ : DISCARD;
                end else if (icache_resp) begin
                    if (!iq_full) begin
                        iq_enq  = 1'b1;
                        iq_data = make_pci(pc, pc_seq, icache_rdata);
                        advance = 1'b1;
                    end else begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = REQ;
                end else if (!iq_full) begin
                    iq_enq    = 1'b1;
                    iq_data   = hold_pkt;
                    advance   = 1'b1;
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                // Keep presenting the address of the abandoned read; the cache sees no change.
                icache_read    = 1'b1;
                icache_address = disc_addr;
                // The stale read completes here; any flush this cycle has already retargeted pc.
                if (icache_resp) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase

        if (rst) begin
            iq_enq         = 1'b0;
            iq_data        = '0;
            icache_read    = 1'b0;
            icache_address = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            hold_pkt  <= '0;
            disc_addr <= '0;
        end else begin
            state <= state_nxt;
            if (hold_ld) begin
                hold_pkt <= make_pci(pc, pc_seq, icache_rdata);
            end
            // Tracks the address of the read issued from REQ so DISCARD can keep it stable.
            if (state == REQ) begin
                disc_addr <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose: directed self-checking bench for instr_fetch (fetch, backpressure, flush, reset).
// Latency: inputs change on the falling edge, outputs are checked 1 time unit later.
// Backpressure: iq_full and icache_resp are driven explicitly per cycle.
module tb_instr_fetch;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        iq_full = 1'b0;
    logic        iq_enq;
    pci_t        iq_data;
    logic        icache_read;
    logic [31:0] icache_address;
    logic [31:0] icache_rdata = '0;
    logic        icache_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .iq_full        (iq_full),
        .iq_enq         (iq_enq),
        .iq_data        (iq_data),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp)
    );

    // Expected packet built field by field from the hand-chosen pc and word.
    function automatic pci_t exp_pkt(input logic [31:0] epc, input logic [31:0] word);
        pci_t p;
        p                 = '0;
        p.pc_info.pc      = epc;
        p.pc_info.next_pc = epc + 32'd4;
        p.pc_info.instr   = word;
        p.pc_info.opcode  = rv32i_opcode'(word[6:0]);
        return p;
    endfunction

    task automatic cyc(input logic r_rst, input logic r_resp, input logic r_full,
                       input logic r_flush, input logic [31:0] r_fpc, input logic [31:0] r_rdata);
        @(negedge clk);
        rst          = r_rst;
        icache_resp  = r_resp;
        iq_full      = r_full;
        flush        = r_flush;
        flush_pc     = r_fpc;
        icache_rdata = r_rdata;
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_p(input string tag, input pci_t obs, input pci_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_b({tag, " read"}, icache_read, 1'b0);
        chk_b({tag, " enq"}, iq_enq, 1'b0);
        chk_w({tag, " addr"}, icache_address, 32'h0);
        chk_p({tag, " data"}, iq_data, '0);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        chk_idle("reset");
        cyc(1, 1, 0, 0, 0, 32'h13);
        chk_idle("reset_resp");

        // 1: back-to-back fetch, one word per resp
        cyc(0, 1, 0, 0, 0, 32'h0000_0013);
        chk_b("t1 read0", icache_read, 1'b1);
        chk_w("t1 addr0", icache_address, 32'h60);
        chk_b("t1 enq0", iq_enq, 1'b1);
        chk_p("t1 pkt0", iq_data, exp_pkt(32'h60, 32'h13));
        chk_w("t1 op0", 32'(iq_data.pc_info.opcode), 32'(op_imm));
        cyc(0, 1, 0, 0, 0, 32'h0000_0013);
        chk_b("t1 enq1", iq_enq, 1'b1);
        chk_p("t1 pkt1", iq_data, exp_pkt(32'h64, 32'h13));
        cyc(0, 1, 0, 0, 0, 32'h0000_0013);
        chk_w("t1 addr2", icache_address, 32'h68);
        chk_p("t1 pkt2", iq_data, exp_pkt(32'h68, 32'h13));
        chk_w("t1 nextpc2", iq_data.pc_info.next_pc, 32'h6c);

        // 2: queue full when the 0x64 word returns
        cyc(1, 0, 0, 0, 0, 0);
        chk_idle("t2 rst");
        cyc(0, 1, 0, 0, 0, 32'h0000_0013);
        chk_p("t2 pkt60", iq_data, exp_pkt(32'h60, 32'h13));
        cyc(0, 1, 1, 0, 0, 32'h1234_5037);
        chk_b("t2 full enq", iq_enq, 1'b0);
        chk_w("t2 full addr", icache_address, 32'h64);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0, 32'hdead_beef);
            chk_b("t2 hold read", icache_read, 1'b0);
            chk_b("t2 hold enq", iq_enq, 1'b0);
        end
        cyc(0, 0, 0, 0, 0, 32'hdead_beef);
        chk_b("t2 drain enq", iq_enq, 1'b1);
        chk_p("t2 drain pkt", iq_data, exp_pkt(32'h64, 32'h1234_5037));
        chk_w("t2 drain op", 32'(iq_data.pc_info.opcode), 32'(op_lui));
        chk_b("t2 drain read", icache_read, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_b("t2 next read", icache_read, 1'b1);
        chk_w("t2 next addr", icache_address, 32'h68);

        // 3: flush while the 0x68 read is outstanding, resp 3 cycles later
        cyc(0, 0, 0, 1, 32'h200, 0);
        chk_b("t3 flush enq", iq_enq, 1'b0);
        chk_w("t3 flush addr", icache_address, 32'h68);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk_b("t3 disc read", icache_read, 1'b1);
            chk_w("t3 disc addr", icache_address, 32'h68);
        end
        cyc(0, 1, 0, 0, 0, 32'h13);
        chk_b("t3 resp enq", iq_enq, 1'b0);
        chk_w("t3 resp addr", icache_address, 32'h68);
        cyc(0, 0, 0, 0, 0, 0);
        chk_b("t3 redir read", icache_read, 1'b1);
        chk_w("t3 redir addr", icache_address, 32'h200);

        // 4: flush in the same cycle as resp
        cyc(0, 1, 0, 1, 32'h300, 32'h13);
        chk_b("t4 enq", iq_enq, 1'b0);
        chk_w("t4 addr", icache_address, 32'h200);
        cyc(0, 0, 0, 0, 0, 0);
        chk_w("t4 redir addr", icache_address, 32'h300);

        // 5: two flushes while discarding, last one wins
        cyc(0, 0, 0, 1, 32'h400, 0);
        chk_w("t5 f1 addr", icache_address, 32'h300);
        cyc(0, 0, 0, 1, 32'h500, 0);
        chk_w("t5 f2 addr", icache_address, 32'h300);
        chk_b("t5 f2 enq", iq_enq, 1'b0);
        cyc(0, 1, 0, 0, 0, 32'h13);
        chk_b("t5 resp enq", iq_enq, 1'b0);
        cyc(0, 1, 0, 0, 0, 32'h13);
        chk_w("t5 addr", icache_address, 32'h500);
        chk_p("t5 pkt", iq_data, exp_pkt(32'h500, 32'h13));

        // pc wraps modulo 2^32
        cyc(0, 1, 0, 1, 32'hffff_fffc, 32'h13);
        chk_b("wrap flush enq", iq_enq, 1'b0);
        cyc(0, 1, 0, 0, 0, 32'h0000_0067);
        chk_p("wrap pkt", iq_data, exp_pkt(32'hffff_fffc, 32'h67));
        chk_w("wrap nextpc", iq_data.pc_info.next_pc, 32'h0);

        // 6: reset in the middle of HOLD
        cyc(0, 1, 1, 0, 0, 32'h0000_006f);
        chk_w("t6 addr", icache_address, 32'h0);
        chk_b("t6 full enq", iq_enq, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_idle("t6 rst");
        cyc(0, 0, 0, 0, 0, 0);
        chk_b("t6 read", icache_read, 1'b1);
        chk_w("t6 addr60", icache_address, 32'h60);
        chk_b("t6 no held enq", iq_enq, 1'b0);
        cyc(0, 1, 0, 0, 0, 32'h0000_0033);
        chk_p("t6 pkt", iq_data, exp_pkt(32'h60, 32'h33));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
